alu_seq: RTL and testbench

Sequencing stage directly upstream of the 32-bit ALU. Holds an 8-entry register file, accepts one register-register instruction at a time through a valid/ready handshake, and drives the ALU operand and control inputs. It then captures the ALU's registered result and writes it back to the destination register. A side load port initialises registers; a combinational read port exposes them to the bench and to later stages.

---
 rtl/alu_seq.sv | 90 +++++++++
 tb/tb_alu_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: 8-entry register file and 3-state sequencer feeding a registered 32-bit ALU.
// Define ALU_SEQ_R0_ZERO_EN to hardwire R0 to zero.
module alu_seq #(
  parameter int NREGS = 8,
  parameter int RAW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [1:0]     instr_op,
  input  logic           instr_sel,
  input  logic [RAW-1:0] instr_rd,
  input  logic [RAW-1:0] instr_rs1,
  input  logic [RAW-1:0] instr_rs2,
  output logic [31:0]    alu_in_a,
  output logic [31:0]    alu_in_b,
  output logic [1:0]     alu_op,
  output logic           alu_mux_sel,
  input  logic [31:0]    alu_res,
  output logic           wb_valid,
  output logic [RAW-1:0] wb_rd,
  output logic [31:0]    wb_data,
  input  logic           ld_valid,
  input  logic [RAW-1:0] ld_addr,
  input  logic [31:0]    ld_data,
  input  logic [RAW-1:0] rd_addr,
  output logic [31:0]    rd_data
);
`ifdef ALU_SEQ_R0_ZERO_EN
  localparam int LO = 1;
`else
  localparam int LO = 0;
`endif
  typedef enum logic [1:0] {IDLE, EXEC, CAPT} state_t;
  state_t state_q, state_d;
  logic [RAW-1:0] rd_q, wb_rd_q;
  logic [31:0] a_q, b_q, wb_data_q;
  logic [1:0] op_q;
  logic sel_q, wb_valid_q, accept, wb_en;
  logic [31:0] r_q [NREGS];
  always_comb begin
    state_d = state_q;
    accept = (state_q == IDLE) && instr_valid;
    wb_en = state_q == CAPT;
    state_d = (state_q == IDLE) ? (instr_valid ? EXEC : IDLE) : (state_q == EXEC) ? CAPT : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      sel_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
      for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wb_valid_q <= wb_en;
      if (accept) begin
        rd_q <= instr_rd;
        a_q <= r_q[instr_rs1];
        b_q <= r_q[instr_rs2];
        op_q <= instr_op;
        sel_q <= instr_sel;
      end
      if (wb_en) begin
        wb_rd_q <= rd_q;
        wb_data_q <= alu_res;
      end
      // writeback outranks a load to the same register
      for (int i = LO; i < NREGS; i++) begin
        if (wb_en && rd_q == i[RAW-1:0]) r_q[i] <= alu_res;
        else if (ld_valid && ld_addr == i[RAW-1:0]) r_q[i] <= ld_data;
      end
    end
  end
  assign instr_ready = (state_q == IDLE) && !rst;
  assign alu_in_a = a_q;
  assign alu_in_b = b_q;
  assign alu_op = op_q;
  assign alu_mux_sel = sel_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign rd_data = r_q[rd_addr];
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table, hand-written and random instruction checks for alu_seq against a register-array model.
module tb_alu_seq;
`ifdef ALU_SEQ_R0_ZERO_EN
  localparam bit R0Z = 1'b1;
`else
  localparam bit R0Z = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic instr_valid = 1'b0, instr_ready, instr_sel = 1'b0, alu_mux_sel, wb_valid;
  logic ld_valid = 1'b0;
  logic [1:0] instr_op = '0, alu_op;
  logic [2:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0, wb_rd, ld_addr = '0, rd_addr = '0;
  logic [31:0] alu_in_a, alu_in_b, alu_res = '0, wb_data, ld_data = '0, rd_data;
  int tests = 0, fails = 0, cyc = 0;
  logic [31:0] ref_r [8];

  alu_seq dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_sel(instr_sel), .instr_rd(instr_rd),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .alu_in_a(alu_in_a),
    .alu_in_b(alu_in_b), .alu_op(alu_op), .alu_mux_sel(alu_mux_sel),
    .alu_res(alu_res), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [1:0] op, input logic sel, input logic [31:0] a, input logic [31:0] b);
    if (sel) return b;
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a + b;
      default: return a - b;
    endcase
  endfunction

  // external registered ALU
  always @(posedge clk) alu_res <= model(alu_op, alu_mux_sel, alu_in_a, alu_in_b);

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_valid = 1'b0;
    if (!(R0Z && a == 3'd0)) ref_r[a] = d;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_idle", 32'(instr_ready), 32'd1);
  endtask

  task automatic issue(input logic [1:0] op, input logic sel, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] exp, input bit keep, input bit ld_en,
                       input logic [2:0] ld_a, input logic [31:0] ld_d, output int acc);
    logic [31:0] ea, eb;
    instr_op = op;
    instr_sel = sel;
    instr_rd = rd;
    instr_rs1 = rs1;
    instr_rs2 = rs2;
    instr_valid = 1'b1;
    wait_ready();
    ea = ref_r[rs1];
    eb = ref_r[rs2];
    ld_valid = ld_en;
    ld_addr = ld_a;
    ld_data = ld_d;
    acc = cyc;
    tick();
    ld_valid = 1'b0;
    instr_valid = keep;
    if (ld_en && !(R0Z && ld_a == 3'd0)) ref_r[ld_a] = ld_d;
    chk("ready_exec", 32'(instr_ready), 32'd0);
    chk("alu_in_a", alu_in_a, ea);
    chk("alu_in_b", alu_in_b, eb);
    chk("alu_ctl", {29'd0, alu_mux_sel, alu_op}, {29'd0, sel, op});
    tick();
    chk("wb_valid_early", 32'(wb_valid), 32'd0);
    chk("ready_capt", 32'(instr_ready), 32'd0);
    tick();
    chk("wb_valid", 32'(wb_valid), 32'd1);
    chk("wb_rd", 32'(wb_rd), 32'(rd));
    chk("wb_data", wb_data, exp);
    chk("ready_after", 32'(instr_ready), 32'd1);
    if (!(R0Z && rd == 3'd0)) ref_r[rd] = exp;
    rd_addr = rd;
    #1 chk("rd_data_wb", rd_data, ref_r[rd]);
  endtask

  task automatic collide(input logic [2:0] la, input logic [31:0] ld);
    load(3'd1, 32'd4);
    load(3'd2, 32'd5);
    instr_op = 2'd2;
    instr_sel = 1'b0;
    instr_rd = 3'd3;
    instr_rs1 = 3'd1;
    instr_rs2 = 3'd2;
    instr_valid = 1'b1;
    wait_ready();
    tick();
    instr_valid = 1'b0;
    tick();
    ld_valid = 1'b1;
    ld_addr = la;
    ld_data = ld;
    tick();
    ld_valid = 1'b0;
    ref_r[la] = ld;
    ref_r[3] = 32'd9;
    rd_addr = 3'd3;
    #1 chk("collide_wb", rd_data, 32'd9);
    rd_addr = la;
    #1 chk("collide_ld", rd_data, ref_r[la]);
  endtask

  typedef struct {
    logic [1:0] op;
    logic sel;
    logic [2:0] rd, rs1, rs2;
    logic [31:0] a, b, exp;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int acc [3];
    int dummy;
    logic [31:0] e;
    tbl[0] = '{2'd2, 1'b0, 3'd3, 3'd1, 3'd2, 32'd5, 32'd3, 32'd8};
    tbl[1] = '{2'd3, 1'b0, 3'd4, 3'd2, 3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE};
    tbl[2] = '{2'd2, 1'b0, 3'd7, 3'd1, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd0};
    tbl[3] = '{2'd0, 1'b0, 3'd3, 3'd5, 3'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0};
    tbl[4] = '{2'd1, 1'b0, 3'd4, 3'd5, 3'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0};
    tbl[5] = '{2'd0, 1'b1, 3'd7, 3'd5, 3'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0FF0_0FF0};
    tbl[6] = '{2'd3, 1'b1, 3'd1, 3'd5, 3'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0FF0_0FF0};
    tbl[7] = '{2'd2, 1'b0, 3'd0, 3'd1, 3'd2, 32'd10, 32'd20, 32'd30};
    for (int i = 0; i < 8; i++) ref_r[i] = '0;
    tick();
    tick();
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_alu_a", alu_in_a, 32'd0);
    chk("rst_alu_b", alu_in_b, 32'd0);
    chk("rst_ctl", {29'd0, alu_mux_sel, alu_op}, 32'd0);
    chk("rst_wb", {wb_valid, 28'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    #1 chk("ready_post_rst", 32'(instr_ready), 32'd1);
    tick();
    for (int i = 0; i < 8; i++) begin
      load(tbl[i].rs1, tbl[i].a);
      load(tbl[i].rs2, tbl[i].b);
      issue(tbl[i].op, tbl[i].sel, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].exp, 1'b0, 1'b0, 3'd0, 32'd0, dummy);
      rd_addr = tbl[i].rd;
      #1 chk("tbl_reg", rd_data, (R0Z && tbl[i].rd == 3'd0) ? 32'd0 : tbl[i].exp);
    end
    // three instructions with valid held high
    load(3'd1, 32'd100);
    load(3'd2, 32'd7);
    issue(2'd2, 1'b0, 3'd3, 3'd1, 3'd2, 32'd107, 1'b1, 1'b0, 3'd0, 32'd0, acc[0]);
    issue(2'd3, 1'b0, 3'd4, 3'd3, 3'd2, 32'd100, 1'b1, 1'b0, 3'd0, 32'd0, acc[1]);
    issue(2'd1, 1'b0, 3'd5, 3'd4, 3'd3, 32'd100 | 32'd107, 1'b0, 1'b0, 3'd0, 32'd0, acc[2]);
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd3);
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd3);
    // a load on the accept edge is not seen by the instruction
    e = model(2'd2, 1'b0, ref_r[1], ref_r[2]);
    issue(2'd2, 1'b0, 3'd6, 3'd1, 3'd2, e, 1'b0, 1'b1, 3'd1, 32'd999, dummy);
    rd_addr = 3'd1;
    #1 chk("rbw_ld", rd_data, 32'd999);
    collide(3'd3, 32'd7);
    collide(3'd4, 32'h44);
    // reset while in EXEC abandons the instruction
    load(3'd1, 32'd11);
    instr_op = 2'd2;
    instr_rd = 3'd2;
    instr_rs1 = 3'd1;
    instr_rs2 = 3'd1;
    instr_valid = 1'b1;
    wait_ready();
    tick();
    instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_exec_ready", 32'(instr_ready), 32'd0);
    rst = 1'b0;
    #1 chk("rst_exec_ready_after", 32'(instr_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_exec_no_wb", 32'(wb_valid), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      ref_r[i] = '0;
      rd_addr = 3'(i);
      #1 chk("rst_exec_reg", rd_data, 32'd0);
    end
    for (int k = 0; k < 25; k++) begin
      logic [1:0] op;
      logic sel, le;
      logic [2:0] rd, r1, r2, la;
      op = 2'($urandom_range(3));
      sel = ($urandom_range(3) == 0);
      rd = 3'($urandom_range(7));
      r1 = 3'($urandom_range(7));
      r2 = 3'($urandom_range(7));
      la = 3'($urandom_range(7));
      le = $urandom_range(1) == 1;
      if ($urandom_range(1) == 1) load(r1, $urandom);
      if ($urandom_range(1) == 1) load(r2, $urandom);
      e = model(op, sel, ref_r[r1], ref_r[r2]);
      issue(op, sel, rd, r1, r2, e, 1'b0, le, la, $urandom, dummy);
    end
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1 chk("final_reg", rd_data, ref_r[i]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "timeout");
  end
endmodule
